// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage, its interface and its bench.
package cpu_pkg;

  localparam int PC_W    = 9;
  localparam int INSTR_W = 9;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC in, ROM address/data, tagged instruction out and perf counters.
// master = fetch stage, slave = PC/ROM/decode side.
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  pc_t              prog_ctr;
  logic             jump_taken;
  pc_t              rom_addr;
  instr_t           rom_data;
  instr_t           instr;
  pc_t              instr_pc;
  logic             instr_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] squash_count;

  // instr is meaningful only while instr_valid is high; decode has no back-pressure.
  modport master (
    input  prog_ctr, jump_taken, rom_data,
    output rom_addr, instr, instr_pc, instr_valid, halted, fetch_count, squash_count
  );

  modport slave (
    output prog_ctr, jump_taken, rom_data,
    input  rom_addr, instr, instr_pc, instr_valid, halted, fetch_count, squash_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: hides the 1-cycle ROM latency, squashes the wrong-path slot
// after an absolute jump, freezes on HALT and keeps saturating perf counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus,
  output fetch_state_e  state_o
);

  fetch_state_e state_q;
  logic         valid_q;
  logic         halted_q;
  pc_t          instr_pc_q;
  logic         fetch_inc;
  logic         squash_inc;

  assign bus.rom_addr    = bus.prog_ctr;
  assign bus.instr       = bus.rom_data;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign state_o         = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      instr_pc_q <= '0;
    end else begin
      // Tracks the address presented last cycle, so it always tags rom_data.
      instr_pc_q <= bus.prog_ctr;
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          // HALT outranks a simultaneous jump: no squash bubble after HALT.
          if (bus.rom_data == HALT_INSTR) begin
            state_q  <= HALTED;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (bus.jump_taken) begin
            state_q <= SQUASH;
            valid_q <= 1'b0;
          end
        end
        SQUASH: begin
          state_q <= RUN;
          valid_q <= 1'b1;
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_inc  = (state_q == RUN);
  assign squash_inc = (state_q == BOOT) || (state_q == SQUASH);

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .inc_i   (fetch_inc),
    .count_o (bus.fetch_count)
  );

  sat_counter #(.W(CNT_W)) u_squash_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .inc_i   (squash_inc),
    .count_o (bus.squash_count)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 16-bit-counter and a 4-bit-counter build share one PC/ROM/decode model.
module tb_fetch_stage;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- environment: PC stage, ROM, decode jump driver ----------------
  pc_t    pc;
  instr_t rom_data;
  logic   jump_taken = 1'b0;
  pc_t    jump_target = '0;
  logic   force_jump = 1'b0;
  instr_t rom   [512];
  logic   jmp_v [512];
  pc_t    jmp_t [512];

  fetch_stage_if #(.CNT_W(16)) bus16 ();
  fetch_stage_if #(.CNT_W(4))  bus4 ();
  fetch_state_e state16;
  fetch_state_e state4;

  assign bus16.prog_ctr   = pc;
  assign bus16.jump_taken = jump_taken;
  assign bus16.rom_data   = rom_data;
  assign bus4.prog_ctr    = pc;
  assign bus4.jump_taken  = jump_taken;
  assign bus4.rom_data    = rom_data;

  fetch_stage #(.CNT_W(16)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16), .state_o(state16));
  fetch_stage #(.CNT_W(4))  u_dut4  (.clk(clk), .reset(reset), .bus(bus4),  .state_o(state4));

  always @(posedge clk) begin
    if (reset)           pc <= '0;
    else if (jump_taken) pc <= jump_target;
    else                 pc <= pc + 1'b1;
    rom_data <= rom[bus16.rom_addr];
  end

  always @(negedge clk) begin
    jump_taken  = force_jump || jmp_v[bus16.instr_pc];
    jump_target = jmp_t[bus16.instr_pc];
  end

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [17:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int p, input int i);
    exp_q.push_back({p[8:0], i[8:0]});
  endtask

  always @(negedge clk) begin
    if (bus16.instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL stream: unexpected pc=0x%0h instr=0x%0h, none expected", bus16.instr_pc, bus16.instr);
      end else begin
        chk("stream", {bus16.instr_pc, bus16.instr}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_maps();
    for (int i = 0; i < 512; i++) begin
      jmp_v[i] = 1'b0;
      jmp_t[i] = '0;
    end
  endtask

  task automatic chk_boot(input string tag);
    chk({tag, "_valid"},  bus16.instr_valid, 0);
    chk({tag, "_halted"}, bus16.halted, 0);
    chk({tag, "_fetch"},  bus16.fetch_count, 0);
    chk({tag, "_squash"}, bus16.squash_count, 0);
    chk({tag, "_state"},  state16, BOOT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Phase A: straight run, jump 5->40, jump 42->7 onto HALT.
    clear_maps();
    for (int i = 0; i < 512; i++) rom[i] = 9'h000;
    for (int i = 0; i < 7; i++) rom[i] = instr_t'(i + 1);
    rom[7] = HALT_INSTR;
    rom[40] = 9'h0A0; rom[41] = 9'h0A1; rom[42] = 9'h0A2; rom[43] = 9'h0A3;
    jmp_v[5] = 1'b1;  jmp_t[5] = 9'd40;
    jmp_v[42] = 1'b1; jmp_t[42] = 9'd7;
    for (int i = 0; i < 6; i++) push(i, i + 1);
    push(40, 'hA0); push(41, 'hA1); push(42, 'hA2); push(7, 'h1FF);
    step(2);
    do_reset();
    chk_boot("a_reset");
    chk("a_instr_pc_reset", bus16.instr_pc, 0);
    step(1);
    chk("a_boot_squash", bus16.squash_count, 1);
    step(4);
    chk("a_fetch4", bus16.fetch_count, 4);
    step(2);
    chk("a_sq_valid", bus16.instr_valid, 0);
    chk("a_sq_pc", bus16.instr_pc, 6);
    chk("a_sq_state", state16, SQUASH);
    step(1);
    chk("a_sq_count", bus16.squash_count, 2);
    step(5);
    chk("a_halted", bus16.halted, 1);
    chk("a_fetch_halt", bus16.fetch_count, 10);
    chk("a_squash_halt", bus16.squash_count, 3);
    for (int i = 0; i < 22; i++) begin
      force_jump = (i >= 5 && i < 10);
      step(1);
      chk("a_hold_halted", bus16.halted, 1);
      chk("a_hold_valid", bus16.instr_valid, 0);
    end
    force_jump = 1'b0;
    chk("a_fetch_frozen", bus16.fetch_count, 10);
    chk("a_squash_frozen", bus16.squash_count, 3);

    // Phase B: reset out of HALTED; HALT and jump in the same cycle.
    clear_maps();
    rom[0] = 9'h011; rom[1] = 9'h012; rom[2] = 9'h013; rom[3] = HALT_INSTR;
    jmp_v[3] = 1'b1; jmp_t[3] = 9'd50;
    push(0, 'h11); push(1, 'h12); push(2, 'h13); push(3, 'h1FF);
    do_reset();
    chk_boot("b_reset");
    step(5);
    chk("b_halted", bus16.halted, 1);
    chk("b_valid", bus16.instr_valid, 0);
    chk("b_fetch", bus16.fetch_count, 4);
    chk("b_squash", bus16.squash_count, 1);
    step(1);
    chk("b_no_bubble", bus16.squash_count, 1);
    chk("b_state", state16, HALTED);

    // Phase C: 21 straight-line instructions; 4-bit counter must stick at 15.
    clear_maps();
    for (int i = 0; i < 64; i++) rom[i] = instr_t'(i + 'h20);
    for (int i = 0; i < 21; i++) push(i, i + 'h20);
    do_reset();
    step(16);
    chk("c_fetch4_sat", bus4.fetch_count, 15);
    step(5);
    chk("c_fetch4_hold", bus4.fetch_count, 15);
    chk("c_fetch16", bus16.fetch_count, 20);
    chk("c_squash4", bus4.squash_count, 1);
    chk("c_squash16", bus16.squash_count, 1);

    // Phase D: reset pulsed while in SQUASH.
    clear_maps();
    for (int i = 0; i < 64; i++) rom[i] = instr_t'(i + 'h100);
    jmp_v[1] = 1'b1; jmp_t[1] = 9'd30;
    push(0, 'h100); push(1, 'h101);
    do_reset();
    step(3);
    chk("d_sq_state", state16, SQUASH);
    chk("d_sq_valid", bus16.instr_valid, 0);
    chk("d_sq_pc", bus16.instr_pc, 2);
    clear_maps();
    push(0, 'h100);
    do_reset();
    chk_boot("d_reset");
    step(1);
    chk("d_squash", bus16.squash_count, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("d_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
